// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-unit signal bundle: ID/EX/MEM observation inputs and barrier/PC control outputs.
// master = pipeline side, slave = pipeline_hazard_controller.
interface pipeline_hazard_controller_if;
    logic [4:0] idLHSRegisterIndex;
    logic [4:0] idRHSRegisterIndex;
    logic       idUsesLHS;
    logic       idUsesRHS;
    logic       exMemRead;
    logic [4:0] exWriteRegisterIndex;
    logic       exBranchTaken;
    logic       memRequest;
    logic       memReady;

    logic       pcWrite;
    logic       ifIdDontUpdate;
    logic       ifIdFlush;
    logic       idExDontUpdate;
    logic       idExFlush;
    logic       exMemDontUpdate;
    logic [1:0] hazardState;

    modport master (
        output idLHSRegisterIndex, idRHSRegisterIndex, idUsesLHS, idUsesRHS,
               exMemRead, exWriteRegisterIndex, exBranchTaken, memRequest, memReady,
        input  pcWrite, ifIdDontUpdate, ifIdFlush, idExDontUpdate, idExFlush,
               exMemDontUpdate, hazardState
    );

    modport slave (
        input  idLHSRegisterIndex, idRHSRegisterIndex, idUsesLHS, idUsesRHS,
               exMemRead, exWriteRegisterIndex, exBranchTaken, memRequest, memReady,
        output pcWrite, ifIdDontUpdate, ifIdFlush, idExDontUpdate, idExFlush,
               exMemDontUpdate, hazardState
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Mealy stall/flush controller for the 5-stage pipeline barriers and PC.
// Optional statistics counters are built only when HAZARD_STATS_EN is defined.
module pipeline_hazard_controller #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned STAT_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_controller_if.slave hz,
    output logic [STAT_WIDTH-1:0] stallCycles,
    output logic [STAT_WIDTH-1:0] flushCount,
    output logic [STAT_WIDTH-1:0] memWaitCycles
);
    localparam logic [1:0] RUN          = 2'd0;
    localparam logic [1:0] LOAD_STALL   = 2'd1;
    localparam logic [1:0] BRANCH_FLUSH = 2'd2;
    localparam logic [1:0] MEM_WAIT     = 2'd3;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    logic [1:0] state;
    logic [1:0] nextState;
    logic [3:0] cnt;
    logic [3:0] nextCnt;
    logic       loadUse;
    logic       memBusy;
    logic       stallEvent;
    logic       flushEvent;

    assign loadUse = hz.exMemRead && (hz.exWriteRegisterIndex != 5'd0) &&
                     ((hz.idUsesLHS && (hz.idLHSRegisterIndex == hz.exWriteRegisterIndex)) ||
                      (hz.idUsesRHS && (hz.idRHSRegisterIndex == hz.exWriteRegisterIndex)));
    assign memBusy = hz.memRequest && !hz.memReady;
    assign hz.hazardState = state;

    always_comb begin
        hz.pcWrite         = 1'b1;
        hz.ifIdDontUpdate  = 1'b0;
        hz.ifIdFlush       = 1'b0;
        hz.idExDontUpdate  = 1'b0;
        hz.idExFlush       = 1'b0;
        hz.exMemDontUpdate = 1'b0;
        nextState          = RUN;
        nextCnt            = cnt;
        stallEvent         = 1'b0;
        flushEvent         = 1'b0;

        if (rst) begin
            hz.pcWrite   = 1'b0;
            hz.ifIdFlush = 1'b1;
            hz.idExFlush = 1'b1;
            nextCnt      = '0;
        end else if (memBusy) begin
            // Freeze wins in every state; cnt is kept so an interrupted flush resumes.
            hz.pcWrite         = 1'b0;
            hz.ifIdDontUpdate  = 1'b1;
            hz.idExDontUpdate  = 1'b1;
            hz.exMemDontUpdate = 1'b1;
            nextState          = MEM_WAIT;
        end else begin
            case (state)
                RUN, LOAD_STALL: begin
                    if (hz.exBranchTaken) begin
                        hz.ifIdFlush = 1'b1;
                        hz.idExFlush = 1'b1;
                        flushEvent   = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            nextState = BRANCH_FLUSH;
                            nextCnt   = FLUSH_INIT;
                        end
                    end else if (loadUse) begin
                        hz.pcWrite        = 1'b0;
                        hz.ifIdDontUpdate = 1'b1;
                        hz.idExFlush      = 1'b1;
                        stallEvent        = 1'b1;
                        nextState         = LOAD_STALL;
                    end
                end
                BRANCH_FLUSH: begin
                    hz.ifIdFlush = 1'b1;
                    hz.idExFlush = 1'b1;
                    nextCnt      = cnt - 4'd1;
                    nextState    = (cnt == 4'd1) ? RUN : BRANCH_FLUSH;
                end
                MEM_WAIT: begin
                    nextState = (cnt != 4'd0) ? BRANCH_FLUSH : RUN;
                end
                default: nextState = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCycles   <= '0;
            flushCount    <= '0;
            memWaitCycles <= '0;
        end else begin
            if (stallEvent && (stallCycles != '1)) begin
                stallCycles <= stallCycles + 1'b1;
            end
            if (flushEvent && (flushCount != '1)) begin
                flushCount <= flushCount + 1'b1;
            end
            if (memBusy && (memWaitCycles != '1)) begin
                memWaitCycles <= memWaitCycles + 1'b1;
            end
        end
    end
`else
    assign stallCycles   = '0;
    assign flushCount    = '0;
    assign memWaitCycles = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: directed cases then random traffic vs. a rule-level model.
`timescale 1ns/1ps
module tb_pipeline_hazard_controller;
    localparam int unsigned FC = 2;
    localparam int unsigned SW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [SW-1:0] stallCycles, flushCount, memWaitCycles;

    pipeline_hazard_controller_if hz();

    pipeline_hazard_controller #(.FLUSH_CYCLES(FC), .STAT_WIDTH(SW)) dut (
        .clk(clk),
        .rst(rst),
        .hz(hz),
        .stallCycles(stallCycles),
        .flushCount(flushCount),
        .memWaitCycles(memWaitCycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]    ctl;   // pcWrite, ifIdDontUpdate, ifIdFlush, idExDontUpdate, idExFlush, exMemDontUpdate
        logic [1:0]    st;
        logic [SW-1:0] sStall;
        logic [SW-1:0] sFlush;
        logic [SW-1:0] sWait;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   fails  = 0;
    bit   driverDone = 0;

    // Reference model: pending flush cycles, waiting-on-memory flag, bubble-just-issued flag.
    int unsigned flushLeft = 0;
    bit          waiting   = 0;
    bit          bubbled   = 0;
    longint unsigned nStall = 0, nFlush = 0, nWait = 0;

    function automatic logic [SW-1:0] statOf(input longint unsigned v);
`ifdef HAZARD_STATS_EN
        return (v > longint'({SW{1'b1}})) ? {SW{1'b1}} : SW'(v);
`else
        return (v == 0) ? '0 : '0;
`endif
    endfunction

    task automatic step(input bit r, input int rs1, input int rs2, input bit uL, input bit uR,
                        input bit mRd, input int rd, input bit br, input bit req, input bit rdy);
        exp_t e;
        bit lu;
        bit busy;
        @(posedge clk);
        #1;
        rst                        = r;
        hz.idLHSRegisterIndex      = 5'(rs1);
        hz.idRHSRegisterIndex      = 5'(rs2);
        hz.idUsesLHS               = uL;
        hz.idUsesRHS               = uR;
        hz.exMemRead               = mRd;
        hz.exWriteRegisterIndex    = 5'(rd);
        hz.exBranchTaken           = br;
        hz.memRequest              = req;
        hz.memReady                = rdy;

        e.st     = waiting ? 2'd3 : (flushLeft > 0) ? 2'd2 : bubbled ? 2'd1 : 2'd0;
        e.sStall = statOf(nStall);
        e.sFlush = statOf(nFlush);
        e.sWait  = statOf(nWait);

        lu   = mRd && rd != 0 && ((uL && rs1 == rd) || (uR && rs2 == rd));
        busy = req && !rdy;
        bubbled = 0;
        if (r) begin
            e.ctl = 6'b001010;
            flushLeft = 0; waiting = 0; nStall = 0; nFlush = 0; nWait = 0;
        end else if (busy) begin
            e.ctl = 6'b010101;
            waiting = 1;
            nWait++;
        end else if (waiting) begin
            e.ctl = 6'b100000;
            waiting = 0;
        end else if (flushLeft > 0) begin
            e.ctl = 6'b101010;
            flushLeft--;
        end else if (br) begin
            e.ctl = 6'b101010;
            flushLeft = FC - 1;
            nFlush++;
        end else if (lu) begin
            e.ctl = 6'b010010;
            bubbled = 1;
            nStall++;
        end else begin
            e.ctl = 6'b100000;
        end
        expQ.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares whatever the driver has queued for this cycle.
    always @(negedge clk) begin
        exp_t e;
        logic [5:0] act;
        if (expQ.size() > 0) begin
            e   = expQ.pop_front();
            act = {hz.pcWrite, hz.ifIdDontUpdate, hz.ifIdFlush, hz.idExDontUpdate,
                   hz.idExFlush, hz.exMemDontUpdate};
            checks++;
            if (act !== e.ctl) begin
                fails++;
                $display("FAIL controls t=%0t got=%b want=%b", $time, act, e.ctl);
            end
            checks++;
            if (hz.hazardState !== e.st) begin
                fails++;
                $display("FAIL hazardState t=%0t got=%0d want=%0d", $time, hz.hazardState, e.st);
            end
            checks++;
            if ({stallCycles, flushCount, memWaitCycles} !== {e.sStall, e.sFlush, e.sWait}) begin
                fails++;
                $display("FAIL stats t=%0t got=%0d/%0d/%0d want=%0d/%0d/%0d", $time,
                         stallCycles, flushCount, memWaitCycles, e.sStall, e.sFlush, e.sWait);
            end
        end
    end

    initial begin
        hz.idLHSRegisterIndex = '0; hz.idRHSRegisterIndex = '0;
        hz.idUsesLHS = 0; hz.idUsesRHS = 0; hz.exMemRead = 0;
        hz.exWriteRegisterIndex = '0; hz.exBranchTaken = 0;
        hz.memRequest = 0; hz.memReady = 0;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // load-use on x5 via rs1, then via rs2, then back-to-back
        step(0, 5, 1, 1, 1, 1, 5, 0, 0, 0);
        idle(1);
        step(0, 2, 7, 1, 1, 1, 7, 0, 0, 0);
        step(0, 3, 3, 1, 0, 1, 3, 0, 0, 0);
        idle(1);
        // rd = x0 never stalls; unused operand does not stall
        step(0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
        step(0, 9, 4, 0, 1, 1, 9, 0, 0, 0);
        // taken branch
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(2);
        // three busy memory cycles then ready
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(1);
        // branch held across a memory wait
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(3);
        // memory wait interrupting a branch flush
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(2);
        // reset inside a memory wait
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);

        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(99) < 2,
                 $urandom_range(3), $urandom_range(3),
                 $urandom_range(1), $urandom_range(1),
                 $urandom_range(99) < 45, $urandom_range(3),
                 $urandom_range(99) < 15,
                 $urandom_range(99) < 30, $urandom_range(1));
        end
        idle(1);
        driverDone = 1;
    end

    initial begin
        int budget;
        budget = 0;
        wait (driverDone == 1);
        while (expQ.size() > 0 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        #1;
        if (expQ.size() > 0) begin
            fails++;
            $display("FAIL drain left=%0d want=0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time=%0t want=finish", $time);
        $fatal(1, "timeout");
    end
endmodule
